// File: rtl/adc7478_rx.sv
// AD7478 serial ADC reader: frames one 16-SCLK conversion per request.
// Ports: clk/reset, start (level request), cs/sclk/so to the ADC,
//   eoc (1-clk pulse with new data), data (last 8-bit sample).
module adc7478_rx #(
  parameter int ADC_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cs,
  output logic       sclk,
  input  logic       so,
  output logic       eoc,
  output logic [7:0] data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE,
    S_QUIET
  } state_t;

  localparam int DIV_W = $clog2(ADC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ADC_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(ADC_DIV / 2 - 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [3:0]       bit_cnt, bit_n;
  logic [7:0]       shreg;
  logic             sample;

  // SCLK rises on the edge that leaves the low half of a period;
  // ADC samples 4..11 (bit_cnt 3..10) carry the byte, MSB first.
  assign sample = (state == S_CONV) && (div_cnt == HALF_LAST) &&
                  (bit_cnt >= 4'd3) && (bit_cnt <= 4'd10);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    unique case (state)
      S_IDLE: begin
        div_n = '0;
        bit_n = '0;
        if (start) state_n = S_CONV;
      end
      S_CONV: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == 4'd15) begin
            bit_n   = '0;
            state_n = S_DONE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      S_DONE: begin
        div_n   = '0;
        bit_n   = '0;
        state_n = S_QUIET;
      end
      S_QUIET: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == 4'd1) begin
            bit_n   = '0;
            state_n = S_IDLE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pins are registered from next-state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data    <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b1;
      eoc     <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      if (sample) shreg <= {shreg[6:0], so};
      if (state == S_CONV && state_n == S_DONE) data <= shreg;
      cs      <= (state_n != S_CONV);
      sclk    <= !((state_n == S_CONV) && (div_n <= HALF_LAST));
      eoc     <= (state_n == S_DONE);
    end
  end

endmodule

// File: rtl/adc7478_b_mod_fcs.sv
// 802.11b backscatter tag datapath: ADC reader, DBPSK scrambler/encoder, CRC-32.
// Ports: clk/reset; adc_* ADC pins and result; s_in tag bits; sym_stb/mod_en/mod_out
//   modulator; crc_stb/crc_en/crc_clr/crc_val FCS.
module adc7478_b_mod_fcs #(
  parameter int          ADC_DIV  = 4,
  parameter logic [31:0] CRC_POLY = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_start,
  output logic        adc_cs,
  output logic        adc_sclk,
  input  logic        adc_so,
  output logic        adc_eoc,
  output logic [7:0]  adc_data,
  input  logic        s_in,
  input  logic        sym_stb,
  input  logic        mod_en,
  output logic        mod_out,
  input  logic        crc_stb,
  input  logic        crc_en,
  input  logic        crc_clr,
  output logic [31:0] crc_val
);

  adc7478_rx #(
    .ADC_DIV(ADC_DIV)
  ) u_rx (
    .clk  (clk),
    .reset(reset),
    .start(adc_start),
    .cs   (adc_cs),
    .sclk (adc_sclk),
    .so   (adc_so),
    .eoc  (adc_eoc),
    .data (adc_data)
  );

  logic [7:1] e;
  logic       e_new;
  logic       fb;

  // Self-synchronizing scrambler x^7+x^4+1, then differential encode.
  assign e_new = s_in ^ e[4] ^ e[7];

  always_ff @(posedge clk) begin
    if (reset || !mod_en) begin
      e       <= '0;
      mod_out <= 1'b0;
    end else if (sym_stb) begin
      e       <= {e[6:1], e_new};
      mod_out <= mod_out ^ e_new;
    end
  end

  // Zero-init, no final inversion: the CRC stays linear over XOR.
  assign fb = crc_val[31] ^ s_in;

  always_ff @(posedge clk) begin
    if (reset || crc_clr) begin
      crc_val <= '0;
    end else if (crc_stb && crc_en) begin
      crc_val <= {crc_val[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'd0);
    end
  end

endmodule

// File: tb/tb_adc7478_b_mod_fcs.sv
// Directed bench for adc7478_b_mod_fcs: ADC serial model, modulator vectors,
// CRC known values and linearity.
module tb_adc7478_b_mod_fcs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_start = 1'b0;
  logic        adc_cs;
  logic        adc_sclk;
  logic        adc_so = 1'b0;
  logic        adc_eoc;
  logic [7:0]  adc_data;
  logic        s_in = 1'b0;
  logic        sym_stb = 1'b0;
  logic        mod_en = 1'b0;
  logic        mod_out;
  logic        crc_stb = 1'b0;
  logic        crc_en = 1'b0;
  logic        crc_clr = 1'b0;
  logic [31:0] crc_val;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  adc7478_b_mod_fcs dut (
    .clk      (clk),
    .reset    (reset),
    .adc_start(adc_start),
    .adc_cs   (adc_cs),
    .adc_sclk (adc_sclk),
    .adc_so   (adc_so),
    .adc_eoc  (adc_eoc),
    .adc_data (adc_data),
    .s_in     (s_in),
    .sym_stb  (sym_stb),
    .mod_en   (mod_en),
    .mod_out  (mod_out),
    .crc_stb  (crc_stb),
    .crc_en   (crc_en),
    .crc_clr  (crc_clr),
    .crc_val  (crc_val)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ADC model: 16-bit frame 000_dddddddd_00000, bit 1 valid after cs falls,
  // next bit driven after each SCLK rising edge.
  logic [7:0]  tbl [8];
  int          conv_i = 0;
  int          so_idx = 0;
  logic [15:0] so_word = '0;

  always @(negedge adc_cs) begin
    so_word = {3'b000, tbl[conv_i % 8], 5'b00000};
    conv_i++;
    so_idx = 0;
    adc_so = so_word[15];
  end

  always @(posedge adc_sclk) begin
    if (adc_cs == 1'b0) begin
      #1;
      so_idx++;
      if (so_idx < 16) adc_so = so_word[15-so_idx];
      else adc_so = 1'b0;
    end
  end

  int         w_cs_low, w_eocs, w_rises, w_gap_min;
  logic [7:0] w_data [4];

  task automatic run_window(input int n, input int drop_at);
    logic pcs, psclk;
    int   hi_run;
    bit   seen_low;
    pcs = adc_cs;
    psclk = adc_sclk;
    hi_run = 0;
    seen_low = 0;
    w_cs_low = 0;
    w_eocs = 0;
    w_rises = 0;
    w_gap_min = 1000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!adc_cs) begin
        w_cs_low++;
        if (pcs && seen_low && hi_run < w_gap_min) w_gap_min = hi_run;
        seen_low = 1;
        hi_run = 0;
      end else begin
        hi_run++;
      end
      if (adc_sclk && !psclk) w_rises++;
      if (adc_eoc) begin
        if (w_eocs < 4) w_data[w_eocs] = adc_data;
        w_eocs++;
      end
      pcs = adc_cs;
      psclk = adc_sclk;
      if (i == drop_at) adc_start = 1'b0;
    end
  endtask

  task automatic mod_step(input logic b);
    sym_stb = 1'b1;
    s_in = b;
    @(negedge clk);
    sym_stb = 1'b0;
  endtask

  task automatic crc_feed64(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      crc_stb = 1'b1;
      s_in = d[i];
      @(negedge clk);
    end
    crc_stb = 1'b0;
  endtask

  task automatic crc_clear();
    crc_clr = 1'b1;
    @(negedge clk);
    crc_clr = 1'b0;
  endtask

  function automatic logic [31:0] crc_model(input logic [63:0] d);
    logic [31:0] c;
    c = '0;
    for (int i = 63; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  int          mod_exp [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 0};
  logic [63:0] a, b;
  logic [31:0] va, vb, vab;

  initial begin
    tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl[2] = 8'hF0; tbl[3] = 8'h81;
    tbl[4] = 8'h5A; tbl[5] = 8'h0F; tbl[6] = 8'hC3; tbl[7] = 8'h18;

    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, adc_cs}, 32'd1);
    check("rst_sclk", {31'd0, adc_sclk}, 32'd1);
    check("rst_eoc", {31'd0, adc_eoc}, 32'd0);
    check("rst_data", {24'd0, adc_data}, 32'd0);
    check("rst_mod", {31'd0, mod_out}, 32'd0);
    check("rst_crc", crc_val, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Modulator reference sequence 1,0,0,...
    mod_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      mod_step(i == 0);
      check($sformatf("mod_step%0d", i + 1), {31'd0, mod_out},
            mod_exp[i]);
    end

    mod_en = 1'b0;
    @(negedge clk);
    mod_en = 1'b1;
    mod_step(1'b1);
    check("mod_restart", {31'd0, mod_out}, 32'd1);
    mod_en = 1'b0;
    @(negedge clk);
    check("mod_dis", {31'd0, mod_out}, 32'd0);
    mod_step(1'b1);
    check("mod_dis_stb", {31'd0, mod_out}, 32'd0);

    mod_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mod_step(1'b0);
      check("mod_zero", {31'd0, mod_out}, 32'd0);
    end

    // Both strobes in one clk, from cleared CRC and zero scrambler state.
    crc_en = 1'b1;
    crc_clear();
    check("crc_clr", crc_val, 32'd0);
    sym_stb = 1'b1;
    crc_stb = 1'b1;
    s_in = 1'b1;
    @(negedge clk);
    sym_stb = 1'b0;
    crc_stb = 1'b0;
    check("both_mod", {31'd0, mod_out}, 32'd1);
    check("crc_one", crc_val, POLY);

    crc_en = 1'b0;
    crc_stb = 1'b1;
    @(negedge clk);
    crc_stb = 1'b0;
    crc_en = 1'b1;
    check("crc_en_low", crc_val, POLY);

    crc_clear();
    for (int i = 0; i < 8; i++) begin
      crc_stb = 1'b1;
      s_in = 1'b0;
      @(negedge clk);
    end
    crc_stb = 1'b0;
    check("crc_zero8", crc_val, 32'd0);

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    crc_clear();
    crc_feed64(a);
    va = crc_val;
    check("crc_a", va, crc_model(a));
    crc_clear();
    crc_feed64(b);
    vb = crc_val;
    check("crc_b", vb, crc_model(b));
    crc_clear();
    crc_feed64(a ^ b);
    vab = crc_val;
    check("crc_lin", vab, va ^ vb);

    crc_clr = 1'b1;
    crc_stb = 1'b1;
    s_in = 1'b1;
    @(negedge clk);
    crc_clr = 1'b0;
    crc_stb = 1'b0;
    check("crc_clr_prio", crc_val, 32'd0);

    // Single conversion from a 1-clk start pulse.
    adc_start = 1'b1;
    run_window(100, 0);
    check("adc1_cs_low", w_cs_low, 32'd64);
    check("adc1_eocs", w_eocs, 32'd1);
    check("adc1_data", {24'd0, w_data[0]}, 32'h000000A5);
    check("adc1_rises", w_rises, 32'd16);

    // Back-to-back conversions; start drops during the third.
    adc_start = 1'b1;
    run_window(300, 149);
    check("adcc_eocs", w_eocs, 32'd3);
    check("adcc_d0", {24'd0, w_data[0]}, 32'h0000003C);
    check("adcc_d1", {24'd0, w_data[1]}, 32'h000000F0);
    check("adcc_d2", {24'd0, w_data[2]}, 32'h00000081);
    check("adcc_gap", {31'd0, w_gap_min >= 8}, 32'd1);
    check("adcc_cs_low", w_cs_low, 32'd192);
    check("adcc_rises", w_rises, 32'd48);
    check("adc_convs", conv_i, 32'd4);

    // Reset in the middle of a conversion.
    adc_start = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    adc_start = 1'b0;
    @(negedge clk);
    check("rstm_cs", {31'd0, adc_cs}, 32'd1);
    check("rstm_sclk", {31'd0, adc_sclk}, 32'd1);
    check("rstm_eoc", {31'd0, adc_eoc}, 32'd0);
    check("rstm_data", {24'd0, adc_data}, 32'd0);
    reset = 1'b0;
    run_window(100, -1);
    check("rstm_no_eoc", w_eocs, 32'd0);
    check("rstm_cs_low", w_cs_low, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
